// File: rtl/coreriscv_axi4_meta_pkg.sv
// rtl/coreriscv_axi4_meta_pkg.sv - shared widths, requester count and chosen-index constants
package coreriscv_axi4_meta_pkg;

  localparam int IDX_W_DEF = 7;
  localparam int WAY_W_DEF = 1;
  localparam int N_REQ     = 3;

  localparam logic [1:0] CHOSEN_0  = 2'd0;
  localparam logic [1:0] CHOSEN_1  = 2'd1;
  localparam logic [1:0] CHOSEN_2  = 2'd2;
  localparam logic [1:0] PTR_RESET = CHOSEN_2;

  // Successor in the 0->1->2->0 ring; the unreachable value 3 behaves like 2.
  function automatic logic [1:0] rr_next(input logic [1:0] p);
    return (p >= CHOSEN_2) ? CHOSEN_0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/coreriscv_axi4_rr_pick.sv
// rtl/coreriscv_axi4_rr_pick.sv - combinational winner picker, round-robin under CORERISCV_AXI4_META_SCHED_RR_EN
module coreriscv_axi4_rr_pick
  import coreriscv_axi4_meta_pkg::*;
(
  input  logic [N_REQ-1:0] valid,
`ifdef CORERISCV_AXI4_META_SCHED_RR_EN
  input  logic [1:0]       ptr,
`endif
  output logic [N_REQ-1:0] grant,
  output logic [1:0]       idx
);

`ifdef CORERISCV_AXI4_META_SCHED_RR_EN
  logic [1:0] c0, c1, c2;

  assign c0 = rr_next(ptr);
  assign c1 = rr_next(c0);
  assign c2 = rr_next(c1);

  always_comb begin
    grant = '0;
    idx   = CHOSEN_0;
    if (valid[c0]) begin
      grant[c0] = 1'b1;
      idx       = c0;
    end else if (valid[c1]) begin
      grant[c1] = 1'b1;
      idx       = c1;
    end else if (valid[c2]) begin
      grant[c2] = 1'b1;
      idx       = c2;
    end
  end
`else
  always_comb begin
    grant = '0;
    idx   = CHOSEN_0;
    if (valid[0]) begin
      grant[0] = 1'b1;
      idx      = CHOSEN_0;
    end else if (valid[1]) begin
      grant[1] = 1'b1;
      idx      = CHOSEN_1;
    end else if (valid[2]) begin
      grant[2] = 1'b1;
      idx      = CHOSEN_2;
    end
  end
`endif

endmodule

// File: rtl/coreriscv_axi4_meta_sched.sv
// rtl/coreriscv_axi4_meta_sched.sv - 3:1 metadata access arbiter with one-entry output register
// CORERISCV_AXI4_META_SCHED_RR_EN selects round-robin; otherwise fixed priority 0>1>2.
module coreriscv_axi4_meta_sched
  import coreriscv_axi4_meta_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int WAY_W = WAY_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             io_in_0_valid,
  output logic             io_in_0_ready,
  input  logic [IDX_W-1:0] io_in_0_bits_idx,
  input  logic [WAY_W-1:0] io_in_0_bits_way_en,
  input  logic             io_in_1_valid,
  output logic             io_in_1_ready,
  input  logic [IDX_W-1:0] io_in_1_bits_idx,
  input  logic [WAY_W-1:0] io_in_1_bits_way_en,
  input  logic             io_in_2_valid,
  output logic             io_in_2_ready,
  input  logic [IDX_W-1:0] io_in_2_bits_idx,
  input  logic [WAY_W-1:0] io_in_2_bits_way_en,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [IDX_W-1:0] io_out_bits_idx,
  output logic [WAY_W-1:0] io_out_bits_way_en,
  output logic [1:0]       io_chosen
);

  logic             ld;
  logic             any_valid;
  logic [N_REQ-1:0] valid_vec;
  logic [N_REQ-1:0] grant;
  logic [1:0]       pick;
  logic [IDX_W-1:0] pick_idx;
  logic [WAY_W-1:0] pick_way;

  assign valid_vec = {io_in_2_valid, io_in_1_valid, io_in_0_valid};
  assign any_valid = |valid_vec;
  assign ld        = !io_out_valid || io_out_ready;

  assign io_in_0_ready = ld && grant[0];
  assign io_in_1_ready = ld && grant[1];
  assign io_in_2_ready = ld && grant[2];

`ifdef CORERISCV_AXI4_META_SCHED_RR_EN
  logic [1:0] ptr;

  coreriscv_axi4_rr_pick u_pick (
    .valid (valid_vec),
    .ptr   (ptr),
    .grant (grant),
    .idx   (pick)
  );

  // Pointer moves only when an access is actually taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= PTR_RESET;
    end else if (ld && any_valid) begin
      ptr <= pick;
    end
  end
`else
  coreriscv_axi4_rr_pick u_pick (
    .valid (valid_vec),
    .grant (grant),
    .idx   (pick)
  );
`endif

  always_comb begin
    pick_idx = io_in_0_bits_idx;
    pick_way = io_in_0_bits_way_en;
    case (pick)
      CHOSEN_1: begin
        pick_idx = io_in_1_bits_idx;
        pick_way = io_in_1_bits_way_en;
      end
      CHOSEN_2: begin
        pick_idx = io_in_2_bits_idx;
        pick_way = io_in_2_bits_way_en;
      end
      default: begin
        pick_idx = io_in_0_bits_idx;
        pick_way = io_in_0_bits_way_en;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      io_out_valid       <= 1'b0;
      io_out_bits_idx    <= '0;
      io_out_bits_way_en <= '0;
      io_chosen          <= CHOSEN_0;
    end else if (ld) begin
      io_out_valid <= any_valid;
      if (any_valid) begin
        io_out_bits_idx    <= pick_idx;
        io_out_bits_way_en <= pick_way;
        io_chosen          <= pick;
      end
    end
  end

endmodule

// File: tb/tb_coreriscv_axi4_meta_sched.sv
// tb/tb_coreriscv_axi4_meta_sched.sv - directed self-checking bench for coreriscv_axi4_meta_sched
module tb_coreriscv_axi4_meta_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic       r0, r1, r2;
  logic [6:0] idx0 = 7'h10, idx1 = 7'h11, idx2 = 7'h12;
  logic [0:0] way0 = 1'b0, way1 = 1'b1, way2 = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [6:0] out_idx;
  logic [0:0] out_way;
  logic [1:0] chosen;
  logic [2:0] rdy;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;
  assign rdy = {r2, r1, r0};

  coreriscv_axi4_meta_sched dut (
    .clk                 (clk),
    .reset               (reset),
    .io_in_0_valid       (v0),
    .io_in_0_ready       (r0),
    .io_in_0_bits_idx    (idx0),
    .io_in_0_bits_way_en (way0),
    .io_in_1_valid       (v1),
    .io_in_1_ready       (r1),
    .io_in_1_bits_idx    (idx1),
    .io_in_1_bits_way_en (way1),
    .io_in_2_valid       (v2),
    .io_in_2_ready       (r2),
    .io_in_2_bits_idx    (idx2),
    .io_in_2_bits_way_en (way2),
    .io_out_valid        (out_valid),
    .io_out_ready        (out_ready),
    .io_out_bits_idx     (out_idx),
    .io_out_bits_way_en  (out_way),
    .io_chosen           (chosen)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_valid(input logic [2:0] v);
    {v2, v1, v0} = v;
    #1;
  endtask

  task automatic test_reset();
    step();
    step();
    total++;
    if ({out_valid, chosen, out_idx, out_way} !== 11'd0)
      $display("FAIL reset_outputs: got v=%b ch=%0d idx=%h way=%b, want all zero", out_valid, chosen, out_idx, out_way);
    else passed++;
  endtask

  task automatic test_reset_release();
    int exp_w[4];
`ifdef CORERISCV_AXI4_META_SCHED_RR_EN
    exp_w = '{0, 1, 2, 0};
`else
    exp_w = '{0, 0, 0, 0};
`endif
    reset = 1'b1;
    out_ready = 1'b1;
    set_valid(3'b111);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rdy !== 3'(1 << exp_w[i]))
        $display("FAIL release_ready[%0d]: got %b, want %b", i, rdy, 3'(1 << exp_w[i]));
      else passed++;
      step();
      total++;
      if (out_valid !== 1'b1 || chosen !== 2'(exp_w[i]) || out_idx !== 7'(7'h10 + exp_w[i]))
        $display("FAIL release_chosen[%0d]: got v=%b ch=%0d idx=%h, want v=1 ch=%0d idx=%h",
                 i, out_valid, chosen, out_idx, exp_w[i], 7'h10 + exp_w[i]);
      else passed++;
    end
    set_valid(3'b000);
  endtask

  task automatic test_data_path();
    idx1 = 7'h5A;
    way1 = 1'b1;
    set_valid(3'b010);
    total++;
    if (rdy !== 3'b010) $display("FAIL data_ready: got %b, want 010", rdy);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b1 || out_idx !== 7'h5A || out_way !== 1'b1 || chosen !== 2'd1)
      $display("FAIL data_out: got v=%b idx=%h way=%b ch=%0d, want v=1 idx=5a way=1 ch=1", out_valid, out_idx, out_way, chosen);
    else passed++;
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    idx1 = 7'h33;
    way1 = 1'b0;
    set_valid(3'b010);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (rdy !== 3'b000 || out_valid !== 1'b1 || out_idx !== 7'h5A || out_way !== 1'b1 || chosen !== 2'd1)
        $display("FAIL stall_hold[%0d]: got rdy=%b v=%b idx=%h way=%b ch=%0d, want rdy=000 v=1 idx=5a way=1 ch=1",
                 i, rdy, out_valid, out_idx, out_way, chosen);
      else passed++;
      step();
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (rdy !== 3'b010) $display("FAIL stall_release_ready: got %b, want 010", rdy);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b1 || out_idx !== 7'h33 || out_way !== 1'b0 || chosen !== 2'd1)
      $display("FAIL stall_accept: got v=%b idx=%h way=%b ch=%0d, want v=1 idx=33 way=0 ch=1", out_valid, out_idx, out_way, chosen);
    else passed++;
    set_valid(3'b000);
  endtask

  task automatic test_wrap();
    logic [2:0] exp_second;
    logic [1:0] exp_ch;
`ifdef CORERISCV_AXI4_META_SCHED_RR_EN
    exp_second = 3'b100;
    exp_ch     = 2'd2;
`else
    exp_second = 3'b001;
    exp_ch     = 2'd0;
`endif
    set_valid(3'b100);
    step();
    set_valid(3'b101);
    total++;
    if (rdy !== 3'b001) $display("FAIL wrap_first_ready: got %b, want 001", rdy);
    else passed++;
    step();
    total++;
    if (chosen !== 2'd0) $display("FAIL wrap_first_chosen: got %0d, want 0", chosen);
    else passed++;
    total++;
    if (rdy !== exp_second) $display("FAIL wrap_second_ready: got %b, want %b", rdy, exp_second);
    else passed++;
    step();
    total++;
    if (chosen !== exp_ch || out_idx !== 7'(7'h10 + exp_ch))
      $display("FAIL wrap_second_chosen: got ch=%0d idx=%h, want ch=%0d idx=%h", chosen, out_idx, exp_ch, 7'h10 + exp_ch);
    else passed++;
    set_valid(3'b000);
  endtask

  task automatic test_idle();
    logic [2:0] exp_rdy;
`ifdef CORERISCV_AXI4_META_SCHED_RR_EN
    exp_rdy = 3'b100;
`else
    exp_rdy = 3'b001;
`endif
    set_valid(3'b001);
    step();
    set_valid(3'b000);
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL idle_drop: got v=%b, want 0", out_valid);
    else passed++;
    step();
    step();
    set_valid(3'b101);
    total++;
    if (rdy !== exp_rdy) $display("FAIL idle_ptr_hold: got %b, want %b", rdy, exp_rdy);
    else passed++;
    set_valid(3'b000);
  endtask

  task automatic test_async_reset();
    set_valid(3'b001);
    step();
    out_ready = 1'b0;
    set_valid(3'b000);
    step();
    total++;
    if (out_valid !== 1'b1) $display("FAIL areset_pre_stall: got v=%b, want 1", out_valid);
    else passed++;
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({out_valid, chosen, out_idx, out_way} !== 11'd0)
      $display("FAIL areset_immediate: got v=%b ch=%0d idx=%h way=%b, want all zero", out_valid, chosen, out_idx, out_way);
    else passed++;
    step();
    reset = 1'b1;
    out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0) $display("FAIL areset_no_replay: got v=%b, want 0", out_valid);
    else passed++;
    set_valid(3'b011);
    total++;
    if (rdy !== 3'b001) $display("FAIL areset_ptr: got %b, want 001", rdy);
    else passed++;
    step();
    total++;
    if (out_valid !== 1'b1 || chosen !== 2'd0)
      $display("FAIL areset_first_accept: got v=%b ch=%0d, want v=1 ch=0", out_valid, chosen);
    else passed++;
    set_valid(3'b000);
  endtask

  initial begin
    test_reset();
    test_reset_release();
    test_data_path();
    test_stall();
    test_wrap();
    test_idle();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
